carfield_apb_periph_responder: RTL and testbench
================================================

// Module: carfield_apb_periph_responder
// PURPOSE
//  APB target that consumes the peripheral APB address map (CAN, system timer, advanced timer,
//  watchdog, HyperBus cfg) and forwards each request to the matching peripheral slot.
//  Sits below the AXI->APB bridge of the Periph window (0x2000_1000..0x2000_9FFF).
//  Registered decode and one FSM per transfer. Generates SLVERR for unmapped or disabled slots.
//  A per-transfer timeout prevents a hung peripheral from stalling the host.
// PARAMETERS
//  NumSlots      5                           number of downstream APB slots
//  AddrWidth     32                          APB address width
//  DataWidth     32                          APB data width (pstrb width = DataWidth/8)
//  TimeoutCycles 256                         max ACCESS cycles before abort (>=2)
//  ErrData       32'hBADC_AB1E               prdata returned on decode error / timeout
//  AddrMap       carfield_apb_map_pkg::Map   rule_t[NumSlots] {idx, base, size}
// PORTS
//  clk_i          in   1               clock
//  rst_i          in   1               synchronous reset, active-high
//  slv_psel_i     in   1               upstream APB psel
//  slv_penable_i  in   1               upstream APB penable
//  slv_pwrite_i   in   1               upstream write
//  slv_paddr_i    in   AddrWidth       upstream address
//  slv_pwdata_i   in   DataWidth       upstream write data
//  slv_pstrb_i    in   DataWidth/8     upstream byte strobes
//  slv_pprot_i    in   3               upstream protection
//  slv_prdata_o   out  DataWidth       upstream read data
//  slv_pready_o   out  1               upstream ready
//  slv_pslverr_o  out  1               upstream error
//  slot_en_i      in   NumSlots        runtime slot enable (e.g. CanEnable, PCRS clock-gate)
//  mst_psel_o     out  NumSlots        one-hot downstream select
//  mst_penable_o  out  1               shared downstream penable
//  mst_pwrite_o / mst_paddr_o / mst_pwdata_o / mst_pstrb_o / mst_pprot_o  out  shared, latched copies
//  mst_prdata_i   in   NumSlots x DataWidth   per-slot read data
//  mst_pready_i   in   NumSlots        per-slot ready
//  mst_pslverr_i  in   NumSlots        per-slot error
//  decode_err_o   out  1               1-cycle pulse on decode error
//  timeout_o      out  1               1-cycle pulse on timeout abort
//  err_cnt_o      out  16              saturating count of decode errors + timeouts
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (mst_* address/data regs 0, err_cnt_o 0).
//  Match: base <= addr < base+size, computed in AddrWidth+1 bits (no wrap). size==0 never matches.
//    Overlapping rules: lowest slot index wins. Hit with slot_en_i[idx]==0 = decode error.
//  FSM: IDLE -> (slv_psel_i & !slv_penable_i) latch addr/wdata/strb/prot/write and decode;
//    hit -> SETUP, else -> ERR.
//    SETUP: mst_psel_o[idx]=1, mst_penable_o=0, one cycle -> ACCESS; timer cleared.
//    ACCESS: psel+penable held. mst_pready_i[idx] -> capture prdata/pslverr, go to RESP.
//      Else, if timer==TimeoutCycles-1: drop psel/penable, slverr=1, prdata=ErrData,
//      timeout_o pulse, go to RESP.
//    ERR: decode_err_o pulse, slverr=1, prdata=ErrData -> RESP.
//    RESP: slv_pready_o=1 for exactly one cycle with registered prdata/pslverr -> IDLE.
//  Latency from upstream setup cycle (c0) to slv_pready_o:
//    zero-wait slot c3; each slot wait state +1; decode error c2; timeout c3+TimeoutCycles-1.
//  slv_pready_o is 0 in every state but RESP. slv_prdata_o/slv_pslverr_o are 0 outside RESP.
//  Upstream request changes after latch are ignored until IDLE.
//  Upstream psel dropped mid-transfer: downstream completes normally; RESP still lasts 1 cycle.
//  slot_en_i deasserted during ACCESS: no effect on the active transfer; sampled only in IDLE.
//  err_cnt_o saturates at 16'hFFFF. Decode error and timeout can never occur in the same cycle.
//  Reset asserted mid-transfer: synchronous return to IDLE next edge; mst_psel_o dropped; no response.
// STRUCTURE
//  carfield_apb_map_pkg: rule_t {idx, base, size}, Map built from configuration Can/SystemTimer/
//    SystemAdvancedTimer/SystemWatchdog/HyperBus Base/Size, NumApbSlots=5, state_e.
//  Sub-module carfield_apb_addr_decode: combinational first-match decoder -> {hit, idx}.
//  FSM, timer and counters stay in the top module.
// TESTING
//  Read 0x2000_4000, timer slot pready same cycle, prdata=0x1234 ->
//    mst_psel_o=5'b00010 at c1; slv_pready_o at c3; prdata 0x1234; slverr 0.
//  Write 0x2000_9004, wdata 0xA5A5_A5A5, strb 0xF, HyperBus 2 wait states ->
//    mst_pwdata_o=0xA5A5_A5A5; pready at c5.
//  Read 0x2000_6000 (hole) -> no mst_psel_o; pready c2; slverr=1; prdata=0xBADC_AB1E;
//    decode_err_o pulse; err_cnt_o=1.
//  slot_en_i[0]=0, read 0x2000_1000 -> decode error, CAN psel never asserted.
//  Watchdog slot never ready, TimeoutCycles=8 -> psel dropped; pready at c10; slverr=1;
//    timeout_o pulse.
//  rst_i at c2 of an ACCESS -> all outputs 0 at c3; next request decoded normally.

Source files
------------

// File: rtl/carfield_apb_map_pkg.sv
// Peripheral APB address map for the Carfield Periph window, plus the responder FSM states.
package carfield_apb_map_pkg;

    localparam int unsigned NumApbSlots = 5;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] base;
        logic [31:0] size;
    } rule_t;

    localparam logic [31:0] CanBase                 = 32'h2000_1000;
    localparam logic [31:0] CanSize                 = 32'h0000_1000;
    localparam logic [31:0] SystemTimerBase         = 32'h2000_4000;
    localparam logic [31:0] SystemTimerSize         = 32'h0000_1000;
    localparam logic [31:0] SystemAdvancedTimerBase = 32'h2000_5000;
    localparam logic [31:0] SystemAdvancedTimerSize = 32'h0000_1000;
    localparam logic [31:0] SystemWatchdogBase      = 32'h2000_7000;
    localparam logic [31:0] SystemWatchdogSize      = 32'h0000_1000;
    localparam logic [31:0] HyperBusBase            = 32'h2000_9000;
    localparam logic [31:0] HyperBusSize            = 32'h0000_1000;

    // Concatenation is MSB-first, so slot 0 (CAN) lands at Map[0].
    localparam rule_t [NumApbSlots-1:0] Map = {
        rule_t'{32'd4, HyperBusBase,            HyperBusSize},
        rule_t'{32'd3, SystemWatchdogBase,      SystemWatchdogSize},
        rule_t'{32'd2, SystemAdvancedTimerBase, SystemAdvancedTimerSize},
        rule_t'{32'd1, SystemTimerBase,         SystemTimerSize},
        rule_t'{32'd0, CanBase,                 CanSize}
    };

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR,
        RESP
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/carfield_apb_addr_decode.sv
// Combinational first-match address decoder; the lowest map entry wins on overlap.
module carfield_apb_addr_decode
    import carfield_apb_map_pkg::*;
#(
    parameter int unsigned           NumSlots  = NumApbSlots,
    parameter int unsigned           AddrWidth = 32,
    parameter int unsigned           IdxWidth  = 3,
    parameter rule_t [NumSlots-1:0]  AddrMap   = Map
) (
    input  logic [AddrWidth-1:0] addr,
    output logic                 hit,
    output logic [IdxWidth-1:0]  idx
);

    logic [AddrWidth:0] a;
    logic [AddrWidth:0] lo;
    logic [AddrWidth:0] hi;

    // One extra bit keeps base+size from wrapping at the top of the address space.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        a   = {1'b0, addr};
        lo  = '0;
        hi  = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            lo = {1'b0, AddrWidth'(AddrMap[i].base)};
            hi = lo + {1'b0, AddrWidth'(AddrMap[i].size)};
            if (!hit && (AddrMap[i].size != '0) && (a >= lo) && (a < hi)) begin
                hit = 1'b1;
                idx = IdxWidth'(AddrMap[i].idx);
            end
        end
    end

endmodule

// File: rtl/carfield_apb_periph_responder.sv
// APB target fanning the Periph window out to per-peripheral APB slots, with decode
// error and per-transfer timeout reporting.
module carfield_apb_periph_responder
    import carfield_apb_map_pkg::*;
#(
    parameter int unsigned                 NumSlots      = NumApbSlots,
    parameter int unsigned                 AddrWidth     = 32,
    parameter int unsigned                 DataWidth     = 32,
    parameter int unsigned                 TimeoutCycles = 256,
    parameter logic [DataWidth-1:0]        ErrData       = DataWidth'(32'hBADC_AB1E),
    parameter rule_t [NumSlots-1:0]        AddrMap       = Map
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               slv_psel_i,
    input  logic                               slv_penable_i,
    input  logic                               slv_pwrite_i,
    input  logic [AddrWidth-1:0]               slv_paddr_i,
    input  logic [DataWidth-1:0]               slv_pwdata_i,
    input  logic [DataWidth/8-1:0]             slv_pstrb_i,
    input  logic [2:0]                         slv_pprot_i,
    output logic [DataWidth-1:0]               slv_prdata_o,
    output logic                               slv_pready_o,
    output logic                               slv_pslverr_o,
    input  logic [NumSlots-1:0]                slot_en_i,
    output logic [NumSlots-1:0]                mst_psel_o,
    output logic                               mst_penable_o,
    output logic                               mst_pwrite_o,
    output logic [AddrWidth-1:0]               mst_paddr_o,
    output logic [DataWidth-1:0]               mst_pwdata_o,
    output logic [DataWidth/8-1:0]             mst_pstrb_o,
    output logic [2:0]                         mst_pprot_o,
    input  logic [NumSlots-1:0][DataWidth-1:0] mst_prdata_i,
    input  logic [NumSlots-1:0]                mst_pready_i,
    input  logic [NumSlots-1:0]                mst_pslverr_i,
    output logic                               decode_err_o,
    output logic                               timeout_o,
    output logic [15:0]                        err_cnt_o
);

    localparam int unsigned IdxW   = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned TimerW = $clog2(TimeoutCycles);

    state_e            state;
    logic [IdxW-1:0]   idx_q;
    logic [TimerW-1:0] timer;
    logic              dec_hit;
    logic [IdxW-1:0]   dec_idx;
    logic              req;
    logic              slot_ok;

    carfield_apb_addr_decode #(
        .NumSlots (NumSlots),
        .AddrWidth(AddrWidth),
        .IdxWidth (IdxW),
        .AddrMap  (AddrMap)
    ) i_decode (
        .addr(slv_paddr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign req     = slv_psel_i & ~slv_penable_i;
    assign slot_ok = dec_hit & slot_en_i[dec_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            idx_q         <= '0;
            timer         <= '0;
            slv_prdata_o  <= '0;
            slv_pready_o  <= 1'b0;
            slv_pslverr_o <= 1'b0;
            mst_psel_o    <= '0;
            mst_penable_o <= 1'b0;
            mst_pwrite_o  <= 1'b0;
            mst_paddr_o   <= '0;
            mst_pwdata_o  <= '0;
            mst_pstrb_o   <= '0;
            mst_pprot_o   <= '0;
            decode_err_o  <= 1'b0;
            timeout_o     <= 1'b0;
            err_cnt_o     <= '0;
        end else begin
            decode_err_o <= 1'b0;
            timeout_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        mst_pwrite_o <= slv_pwrite_i;
                        mst_paddr_o  <= slv_paddr_i;
                        mst_pwdata_o <= slv_pwdata_i;
                        mst_pstrb_o  <= slv_pstrb_i;
                        mst_pprot_o  <= slv_pprot_i;
                        idx_q        <= dec_idx;
                        if (slot_ok) begin
                            mst_psel_o <= NumSlots'(1) << dec_idx;
                            state      <= SETUP;
                        end else begin
                            decode_err_o <= 1'b1;
                            err_cnt_o    <= sat_inc16(err_cnt_o);
                            state        <= ERR;
                        end
                    end
                end
                SETUP: begin
                    mst_penable_o <= 1'b1;
                    timer         <= '0;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    if (mst_pready_i[idx_q]) begin
                        mst_psel_o    <= '0;
                        mst_penable_o <= 1'b0;
                        slv_prdata_o  <= mst_prdata_i[idx_q];
                        slv_pslverr_o <= mst_pslverr_i[idx_q];
                        slv_pready_o  <= 1'b1;
                        state         <= RESP;
                    end else if (timer == TimerW'(TimeoutCycles - 1)) begin
                        mst_psel_o    <= '0;
                        mst_penable_o <= 1'b0;
                        slv_prdata_o  <= ErrData;
                        slv_pslverr_o <= 1'b1;
                        slv_pready_o  <= 1'b1;
                        timeout_o     <= 1'b1;
                        err_cnt_o     <= sat_inc16(err_cnt_o);
                        state         <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ERR: begin
                    slv_prdata_o  <= ErrData;
                    slv_pslverr_o <= 1'b1;
                    slv_pready_o  <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    slv_prdata_o  <= '0;
                    slv_pslverr_o <= 1'b0;
                    slv_pready_o  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carfield_apb_periph_responder.sv
// Bench for carfield_apb_periph_responder: directed scenarios plus randomized transfers
// against an address-range / latency reference model and behavioural peripherals.
module tb_carfield_apb_periph_responder;

    localparam int NS = 5;
    localparam int TO = 8;
    localparam logic [31:0] ERRD = 32'hBADC_AB1E;
    localparam logic [31:0] BASES [NS] = '{32'h2000_1000, 32'h2000_4000, 32'h2000_5000,
                                           32'h2000_7000, 32'h2000_9000};
    localparam logic [31:0] SIZE = 32'h1000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]        paddr = '0, pwdata = '0;
    logic [3:0]         pstrb = '0;
    logic [2:0]         pprot = '0;
    logic [31:0]        slv_prdata_o;
    logic               slv_pready_o, slv_pslverr_o;
    logic [NS-1:0]      slot_en = '1;
    logic [NS-1:0]      mst_psel_o;
    logic               mst_penable_o, mst_pwrite_o;
    logic [31:0]        mst_paddr_o, mst_pwdata_o;
    logic [3:0]         mst_pstrb_o;
    logic [2:0]         mst_pprot_o;
    logic [NS-1:0][31:0] mst_prdata;
    logic [NS-1:0]      mst_pready, mst_pslverr;
    logic               decode_err_o, timeout_o;
    logic [15:0]        err_cnt_o;

    int          ws   [NS];   // wait states per slot, -1 = never ready
    logic [31:0] rdv  [NS];
    logic        errv [NS];
    int          acc_cnt = 0;
    logic        clr_en_mid = 1'b0;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    carfield_apb_periph_responder #(
        .NumSlots     (NS),
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .slv_psel_i   (psel),
        .slv_penable_i(penable),
        .slv_pwrite_i (pwrite),
        .slv_paddr_i  (paddr),
        .slv_pwdata_i (pwdata),
        .slv_pstrb_i  (pstrb),
        .slv_pprot_i  (pprot),
        .slv_prdata_o (slv_prdata_o),
        .slv_pready_o (slv_pready_o),
        .slv_pslverr_o(slv_pslverr_o),
        .slot_en_i    (slot_en),
        .mst_psel_o   (mst_psel_o),
        .mst_penable_o(mst_penable_o),
        .mst_pwrite_o (mst_pwrite_o),
        .mst_paddr_o  (mst_paddr_o),
        .mst_pwdata_o (mst_pwdata_o),
        .mst_pstrb_o  (mst_pstrb_o),
        .mst_pprot_o  (mst_pprot_o),
        .mst_prdata_i (mst_prdata),
        .mst_pready_i (mst_pready),
        .mst_pslverr_i(mst_pslverr),
        .decode_err_o (decode_err_o),
        .timeout_o    (timeout_o),
        .err_cnt_o    (err_cnt_o)
    );

    // Peripherals: ready once they have seen ws[s] access cycles.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            mst_pready[s]  = mst_psel_o[s] && mst_penable_o && (ws[s] >= 0) && (acc_cnt >= ws[s]);
            mst_prdata[s]  = rdv[s];
            mst_pslverr[s] = errv[s];
        end
    end

    always @(posedge clk) acc_cnt <= (mst_penable_o && !(|mst_pready)) ? acc_cnt + 1 : 0;

    function automatic int ref_slot(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if (a >= BASES[i] && a < BASES[i] + SIZE) return i;
        return -1;
    endfunction

    // One upstream APB transfer; cycle k counts from the setup cycle c0.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic se,
                           output logic [NS-1:0] psel_seen, output logic [NS-1:0] psel_c1,
                           output logic [31:0] paddr_c1, output logic [31:0] pwdata_c1,
                           output int n_dec, output int n_to, output logic drop_ok);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        pstrb = 4'hF; pprot = 3'b010;
        lat = -1; rd = '0; se = 1'b0; psel_seen = '0; psel_c1 = '0;
        paddr_c1 = '0; pwdata_c1 = '0; n_dec = 0; n_to = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                penable   = 1'b1;
                psel_c1   = mst_psel_o;
                paddr_c1  = mst_paddr_o;
                pwdata_c1 = mst_pwdata_o;
            end
            if (k == 2 && clr_en_mid) slot_en = '0;
            psel_seen |= mst_psel_o;
            n_dec += int'(decode_err_o);
            n_to  += int'(timeout_o);
            if (slv_pready_o) begin
                lat = k; rd = slv_prdata_o; se = slv_pslverr_o;
                break;
            end
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        drop_ok = !slv_pready_o && (slv_prdata_o == '0) && !slv_pslverr_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b1; paddr = 32'h2000_4000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({slv_prdata_o, slv_pready_o, slv_pslverr_o, mst_psel_o, mst_penable_o, mst_pwrite_o,
             mst_paddr_o, mst_pwdata_o, mst_pstrb_o, mst_pprot_o, decode_err_o, timeout_o,
             err_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b pready=%b paddr=%h err_cnt=%0d, required all zero",
                     mst_psel_o, slv_pready_o, mst_paddr_o, err_cnt_o);
        end
        psel = 1'b0;
        @(negedge clk); rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_read_timer();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        for (int s = 0; s < NS; s++) begin ws[s] = 0; rdv[s] = 32'h0; errv[s] = 1'b0; end
        rdv[1] = 32'h1234;
        do_xfer(1'b0, 32'h2000_4000, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        checks++;
        if (c1 !== 5'b00010) begin errors++; $display("FAIL timer_psel_c1: got %b required 00010", c1); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL timer_latency: got %0d required 3", lat); end
        checks++;
        if (rd !== 32'h1234 || se !== 1'b0) begin
            errors++; $display("FAIL timer_data: got %h/%b required 00001234/0", rd, se);
        end
        checks++;
        if (dok !== 1'b1) begin errors++; $display("FAIL timer_resp_one_cycle: got %b required 1", dok); end
    endtask

    task automatic test_write_hyperbus();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        ws[4] = 2;
        do_xfer(1'b1, 32'h2000_9004, 32'hA5A5_A5A5, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        checks++;
        if (pw !== 32'hA5A5_A5A5 || pa !== 32'h2000_9004 || mst_pstrb_o !== 4'hF || mst_pwrite_o !== 1'b1) begin
            errors++;
            $display("FAIL hb_latched: pwdata=%h paddr=%h strb=%h write=%b required a5a5a5a5/20009004/f/1",
                     pw, pa, mst_pstrb_o, mst_pwrite_o);
        end
        checks++;
        if (lat !== 5 || c1 !== 5'b10000) begin
            errors++; $display("FAIL hb_latency: got %0d psel %b required 5 psel 10000", lat, c1);
        end
        ws[4] = 0;
    endtask

    task automatic test_hole();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        do_xfer(1'b0, 32'h2000_6000, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        exp_cnt++;
        checks++;
        if (seen !== '0 || lat !== 2) begin
            errors++; $display("FAIL hole_path: psel %b lat %0d required 00000 lat 2", seen, lat);
        end
        checks++;
        if (rd !== ERRD || se !== 1'b1 || nd !== 1) begin
            errors++; $display("FAIL hole_error: got %h/%b/%0d required badcab1e/1/1", rd, se, nd);
        end
        checks++;
        if (err_cnt_o !== 16'(exp_cnt)) begin
            errors++; $display("FAIL hole_err_cnt: got %0d required %0d", err_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_disabled();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        slot_en = 5'b11110;
        do_xfer(1'b0, 32'h2000_1000, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        exp_cnt++;
        checks++;
        if (seen !== '0 || lat !== 2 || se !== 1'b1 || nd !== 1) begin
            errors++; $display("FAIL can_disabled: psel %b lat %0d slverr %b dec %0d required 00000/2/1/1",
                               seen, lat, se, nd);
        end
        slot_en = '1;
    endtask

    task automatic test_boundary();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        do_xfer(1'b0, 32'h2000_5FFC, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        checks++;
        if (seen !== 5'b00100 || lat !== 3) begin
            errors++; $display("FAIL adv_timer_last_word: psel %b lat %0d required 00100/3", seen, lat);
        end
        do_xfer(1'b0, 32'h2000_8000, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        exp_cnt++;
        checks++;
        if (seen !== '0 || se !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL wdt_end_plus_one: psel %b slverr %b lat %0d required 00000/1/2", seen, se, lat);
        end
    endtask

    task automatic test_timeout();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        ws[3] = -1;
        do_xfer(1'b0, 32'h2000_7000, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        exp_cnt++;
        checks++;
        if (lat !== 3 + TO - 1) begin errors++; $display("FAIL wdt_timeout_latency: got %0d required %0d", lat, 3 + TO - 1); end
        checks++;
        if (rd !== ERRD || se !== 1'b1 || nt !== 1 || mst_psel_o !== '0) begin
            errors++; $display("FAIL wdt_timeout_resp: got %h/%b/%0d psel %b required badcab1e/1/1/00000",
                               rd, se, nt, mst_psel_o);
        end
        checks++;
        if (err_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL wdt_err_cnt: got %0d required %0d", err_cnt_o, exp_cnt); end
        ws[3] = 0;
    endtask

    task automatic test_enable_mid();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        ws[0] = 2; rdv[0] = 32'hCAFE_0001; clr_en_mid = 1'b1;
        do_xfer(1'b0, 32'h2000_1010, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        clr_en_mid = 1'b0; slot_en = '1; ws[0] = 0;
        checks++;
        if (lat !== 5 || rd !== 32'hCAFE_0001 || se !== 1'b0) begin
            errors++; $display("FAIL en_drop_in_access: lat %0d data %h slverr %b required 5/cafe0001/0", lat, rd, se);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd, nt; logic [31:0] rd, pa, pw; logic se, dok; logic [NS-1:0] seen, c1;
        ws[3] = -1;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h2000_7000;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mst_psel_o !== 5'b01000 || mst_penable_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid_access: psel %b penable %b required 01000/1", mst_psel_o, mst_penable_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({slv_prdata_o, slv_pready_o, slv_pslverr_o, mst_psel_o, mst_penable_o, mst_paddr_o,
             decode_err_o, timeout_o, err_cnt_o} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: psel %b penable %b pready %b err_cnt %0d required all zero",
                               mst_psel_o, mst_penable_o, slv_pready_o, err_cnt_o);
        end
        rst = 1'b0; psel = 1'b0; penable = 1'b0; exp_cnt = 0; ws[3] = 0;
        rdv[1] = 32'h5555_AAAA;
        do_xfer(1'b0, 32'h2000_4008, '0, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
        checks++;
        if (lat !== 3 || rd !== 32'h5555_AAAA || c1 !== 5'b00010) begin
            errors++; $display("FAIL rst_mid_recovery: lat %0d data %h psel %b required 3/5555aaaa/00010", lat, rd, c1);
        end
    endtask

    task automatic test_random();
        int lat, nd, nt, s, e_lat; logic [31:0] rd, pa, pw, addr, wd, e_rd; logic se, dok, ok, wr, e_se;
        logic [NS-1:0] seen, c1, e_sel;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NS; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                ws[i]   = (r == 9) ? -1 : r % 4;
                rdv[i]  = $urandom;
                errv[i] = 1'($urandom_range(0, 1));
                slot_en[i] = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 1) == 1)
                addr = BASES[$urandom_range(0, NS - 1)] + ($urandom_range(0, 1023) << 2);
            else
                addr = 32'h2000_0000 + ($urandom_range(0, 32'hAFFF) & ~32'h3);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            s  = ref_slot(addr);
            ok = (s >= 0) && slot_en[s];
            if (!ok) begin
                e_lat = 2; e_rd = ERRD; e_se = 1'b1; e_sel = '0; exp_cnt++;
            end else if (ws[s] < 0) begin
                e_lat = 3 + TO - 1; e_rd = ERRD; e_se = 1'b1; e_sel = NS'(1) << s; exp_cnt++;
            end else begin
                e_lat = 3 + ws[s]; e_rd = rdv[s]; e_se = errv[s]; e_sel = NS'(1) << s;
            end
            do_xfer(wr, addr, wd, lat, rd, se, seen, c1, pa, pw, nd, nt, dok);
            checks++;
            if (lat !== e_lat || rd !== e_rd || se !== e_se) begin
                errors++; $display("FAIL rnd_resp[%0d] addr %h: lat %0d data %h slverr %b required %0d/%h/%b",
                                   it, addr, lat, rd, se, e_lat, e_rd, e_se);
            end
            checks++;
            if (seen !== e_sel || pa !== addr || pw !== wd || dok !== 1'b1) begin
                errors++; $display("FAIL rnd_downstream[%0d] addr %h: psel %b paddr %h pwdata %h drop %b required %b/%h/%h/1",
                                   it, addr, seen, pa, pw, dok, e_sel, addr, wd);
            end
            checks++;
            if (nd !== int'(!ok) || nt !== int'(ok && ws[s] < 0) || err_cnt_o !== 16'(exp_cnt)) begin
                errors++; $display("FAIL rnd_err_flags[%0d]: dec %0d to %0d cnt %0d required %0d/%0d/%0d",
                                   it, nd, nt, err_cnt_o, int'(!ok), int'(ok && ws[s] < 0), exp_cnt);
            end
        end
        slot_en = '1;
    endtask

    initial begin
        for (int s = 0; s < NS; s++) begin ws[s] = 0; rdv[s] = '0; errv[s] = 1'b0; end
        test_reset();
        test_read_timer();
        test_write_hyperbus();
        test_hole();
        test_disabled();
        test_boundary();
        test_timeout();
        test_enable_mid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
